// File: rtl/codix_mem_port_arb_if.sv
// Request/response/memory-side bundle for codix_mem_port_arb.
// master = requesters + memory model, slave = the arbiter.
interface codix_mem_port_arb_if #(
  parameter int NCH = 4,
  parameter int AW  = 32,
  parameter int DW  = 32
);
  logic [NCH-1:0]             req_valid;
  logic [NCH-1:0]             req_ready;
  logic [NCH-1:0]             req_we;
  logic [NCH-1:0][AW-1:0]     req_addr;
  logic [NCH-1:0][DW-1:0]     req_wdata;
  logic [NCH-1:0][DW/8-1:0]   req_be;
  logic [NCH-1:0]             resp_valid;
  logic [DW-1:0]              resp_rdata;
  logic                       mem_req;
  logic                       mem_gnt;
  logic                       mem_we;
  logic [AW-1:0]              mem_addr;
  logic [DW-1:0]              mem_wdata;
  logic [DW/8-1:0]            mem_be;
  logic                       mem_rvalid;
  logic [DW-1:0]              mem_rdata;
  logic                       err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, mem_req, mem_we, mem_addr, mem_wdata, mem_be, err
  );
endinterface

// File: rtl/codix_mem_port_arb.sv
// NCH-channel arbiter onto one in-order memory port; read tags routed back through a FIFO.
// Define CODIX_MEM_ARB_RR_EN for round-robin arbitration, otherwise fixed priority (lowest index).
module codix_mem_port_arb #(
  parameter int NCH   = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input logic               CLK,
  input logic               RST,
  codix_mem_port_arb_if.slave bus
);
  localparam int TW = $clog2(NCH);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PMAX = PW'(DEPTH - 1);

  logic [TW-1:0]  tag_mem [DEPTH];
  logic [PW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic [NCH-1:0] elig;
  logic [TW-1:0]  sel;
  logic           found, xfer, push, pop;

  // Reads need a free tag slot; writes never wait on the FIFO.
  assign elig = bus.req_valid & (bus.req_we | {NCH{cnt < FULL}});

`ifdef CODIX_MEM_ARB_RR_EN
  logic [TW-1:0] rr_ptr;
  int            j;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < NCH; k++) begin
      j = (int'(rr_ptr) + k) % NCH;
      if (!found && elig[j]) begin
        sel   = TW'(j);
        found = 1'b1;
      end
    end
  end

  // Pointer only advances on a real transfer so a stalled grant keeps its winner.
  always_ff @(posedge CLK or posedge RST)
    if (RST)       rr_ptr <= '0;
    else if (xfer) rr_ptr <= (sel == TW'(NCH - 1)) ? '0 : sel + 1'b1;
`else
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (elig[k]) begin
        sel   = TW'(k);
        found = 1'b1;
      end
    end
  end
`endif

  assign xfer = found & bus.mem_gnt;
  assign push = xfer & ~bus.req_we[sel];
  assign pop  = bus.mem_rvalid & (cnt != '0);

  assign bus.mem_req   = found;
  assign bus.req_ready = xfer ? (NCH'(1) << sel) : '0;
  assign bus.mem_we    = found ? bus.req_we[sel]    : 1'b0;
  assign bus.mem_addr  = found ? bus.req_addr[sel]  : '0;
  assign bus.mem_wdata = found ? bus.req_wdata[sel] : '0;
  assign bus.mem_be    = found ? bus.req_be[sel]    : '0;

  always_ff @(posedge CLK)
    if (push) tag_mem[wptr] <= sel;

  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) wptr <= (wptr == PMAX) ? '0 : wptr + 1'b1;
      if (pop)  rptr <= (rptr == PMAX) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end

  // Response stage: one registered slot, sustains a response every cycle.
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      bus.resp_valid <= '0;
      bus.resp_rdata <= '0;
      bus.err        <= 1'b0;
    end else begin
      bus.resp_valid <= pop ? (NCH'(1) << tag_mem[rptr]) : '0;
      if (pop) bus.resp_rdata <= bus.mem_rdata;
      if (bus.mem_rvalid && cnt == '0) bus.err <= 1'b1;
    end
endmodule

// File: tb/tb_codix_mem_port_arb.sv
// Bench for codix_mem_port_arb: directed vector table, hand sequences, and random traffic
// checked against a queue-based reference model.
module tb_codix_mem_port_arb;
  localparam int NCH = 4, AW = 32, DW = 32, DEPTH = 4, BW = DW / 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  codix_mem_port_arb_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus();
  codix_mem_port_arb #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .bus(bus)
  );

  int errors = 0, checks = 0;

  // reference model state
  int             tagq[$];
  logic           err_m;
  logic [NCH-1:0] rsp_m;
  logic [DW-1:0]  rdata_m;
  int             rr_m;

  logic [NCH-1:0][AW-1:0] a_r;
  logic [NCH-1:0][DW-1:0] wd_r;
  logic [NCH-1:0][BW-1:0] be_r;

  typedef struct {
    logic [NCH-1:0] v, we;
    logic           gnt, rv;
    logic [DW-1:0]  rd;
    logic [NCH-1:0] exp_rdy, exp_rsp;
    logic           exp_err;
  } vec_t;
  vec_t tbl[19];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    tagq.delete();
    err_m = 1'b0; rsp_m = '0; rdata_m = '0; rr_m = 0;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0; bus.req_we = '0; bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  task automatic rnd_fields();
    for (int i = 0; i < NCH; i++) begin
      a_r[i] = $urandom; wd_r[i] = $urandom; be_r[i] = BW'($urandom);
    end
  endtask

  // One cycle: drive, check request path before the edge, check response path after it.
  task automatic step(input logic [NCH-1:0] v, input logic [NCH-1:0] we, input logic gnt,
                      input logic rv, input logic [DW-1:0] rd, output logic [NCH-1:0] rdy);
    int sel, idx, t;
    bit found;
    logic [NCH-1:0] exp_rdy;
    bus.req_valid = v; bus.req_we = we; bus.mem_gnt = gnt;
    bus.mem_rvalid = rv; bus.mem_rdata = rd;
    bus.req_addr = a_r; bus.req_wdata = wd_r; bus.req_be = be_r;
    #1;
    found = 0; sel = 0;
    for (int k = 0; k < NCH; k++) begin
`ifdef CODIX_MEM_ARB_RR_EN
      idx = (rr_m + k) % NCH;
`else
      idx = k;
`endif
      if (!found && v[idx] && (we[idx] || tagq.size() < DEPTH)) begin
        found = 1; sel = idx;
      end
    end
    exp_rdy = (found && gnt) ? (NCH'(1) << sel) : '0;
    chk("mem_req",   bus.mem_req,   found);
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("mem_we",    bus.mem_we,    found ? we[sel] : 1'b0);
    chk("mem_addr",  bus.mem_addr,  found ? a_r[sel] : AW'(0));
    chk("mem_wdata", bus.mem_wdata, found ? wd_r[sel] : DW'(0));
    chk("mem_be",    bus.mem_be,    found ? be_r[sel] : BW'(0));
    rdy = bus.req_ready;
    @(posedge CLK);
    rsp_m = '0;
    if (rv) begin
      if (tagq.size() > 0) begin
        t = tagq.pop_front();
        rsp_m = NCH'(1) << t;
        rdata_m = rd;
      end else err_m = 1'b1;
    end
    if (found && gnt) begin
      if (!we[sel]) tagq.push_back(sel);
      rr_m = (sel + 1) % NCH;
    end
    #1;
    chk("resp_valid", bus.resp_valid, rsp_m);
    chk("resp_rdata", bus.resp_rdata, rdata_m);
    chk("err",        bus.err,        err_m);
  endtask

  initial begin
    logic [NCH-1:0] rdy;
    int exp_ch[5];

    tbl[0]  = '{4'b0100, 4'b0000, 1, 0, 32'h0,        4'b0100, 4'b0000, 0};
    tbl[1]  = '{4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0};
    tbl[2]  = '{4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0};
    tbl[3]  = '{4'b0000, 4'b0000, 0, 1, 32'hDEADBEEF, 4'b0000, 4'b0100, 0};
    tbl[4]  = '{4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 0};
    tbl[5]  = '{4'b0001, 4'b0000, 1, 0, 32'h0,        4'b0001, 4'b0000, 0};
    tbl[6]  = '{4'b0010, 4'b0000, 1, 0, 32'h0,        4'b0010, 4'b0000, 0};
    tbl[7]  = '{4'b0100, 4'b0000, 1, 0, 32'h0,        4'b0100, 4'b0000, 0};
    tbl[8]  = '{4'b1000, 4'b0000, 1, 0, 32'h0,        4'b1000, 4'b0000, 0};
    tbl[9]  = '{4'b0011, 4'b0010, 1, 0, 32'h0,        4'b0010, 4'b0000, 0};
    tbl[10] = '{4'b0001, 4'b0000, 1, 1, 32'hA1A1A1A1, 4'b0000, 4'b0001, 0};
    tbl[11] = '{4'b0001, 4'b0000, 1, 0, 32'h0,        4'b0001, 4'b0000, 0};
    tbl[12] = '{4'b0001, 4'b0000, 1, 0, 32'h0,        4'b0000, 4'b0000, 0};
    tbl[13] = '{4'b0000, 4'b0000, 0, 1, 32'hB2B2B2B2, 4'b0000, 4'b0010, 0};
    tbl[14] = '{4'b0000, 4'b0000, 0, 1, 32'hC3C3C3C3, 4'b0000, 4'b0100, 0};
    tbl[15] = '{4'b0000, 4'b0000, 0, 1, 32'hD4D4D4D4, 4'b0000, 4'b1000, 0};
    tbl[16] = '{4'b0000, 4'b0000, 0, 1, 32'hE5E5E5E5, 4'b0000, 4'b0001, 0};
    tbl[17] = '{4'b0000, 4'b0000, 0, 1, 32'h0,        4'b0000, 4'b0000, 1};
    tbl[18] = '{4'b0000, 4'b0000, 0, 0, 32'h0,        4'b0000, 4'b0000, 1};

    for (int i = 0; i < NCH; i++) begin
      a_r[i] = 32'h80 + 32'h40 * i;
      wd_r[i] = 32'h1000 + i;
      be_r[i] = BW'(i + 1);
    end

    idle_inputs();
    #1;
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_rdata", bus.resp_rdata, 0);
    chk("rst_err",        bus.err,        0);
    chk("rst_mem_req",    bus.mem_req,    0);
    chk("rst_req_ready",  bus.req_ready,  0);
    do_reset();

    for (int i = 0; i < 19; i++) begin
      step(tbl[i].v, tbl[i].we, tbl[i].gnt, tbl[i].rv, tbl[i].rd, rdy);
      chk($sformatf("tbl%0d_rdy", i), rdy, tbl[i].exp_rdy);
      chk($sformatf("tbl%0d_rsp", i), bus.resp_valid, tbl[i].exp_rsp);
      chk($sformatf("tbl%0d_err", i), bus.err, tbl[i].exp_err);
      if (i == 0) chk("ch2_addr", a_r[2], 32'h100);
      if (i == 3) chk("deadbeef", bus.resp_rdata, 32'hDEADBEEF);
    end

    // all channels reading continuously with the grant held
    do_reset();
`ifdef CODIX_MEM_ARB_RR_EN
    exp_ch = '{0, 1, 2, 3, 0};
`else
    exp_ch = '{0, 0, 0, 0, 0};
`endif
    for (int c = 0; c < 5; c++) begin
      step(4'b1111, 4'b0000, 1'b1, c > 0, DW'(c), rdy);
      chk($sformatf("order%0d", c), rdy, NCH'(1) << exp_ch[c]);
    end

    // reset with three reads outstanding and a response in the output register
    do_reset();
    for (int c = 0; c < 4; c++) step(NCH'(1) << c, 4'b0000, 1'b1, 1'b0, '0, rdy);
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h5A5A5A5A, rdy);
    chk("pre_rst_resp", bus.resp_valid, 4'b0001);
    idle_inputs();
    #2 RST = 1'b1;
    #1;
    chk("async_rst_resp_valid", bus.resp_valid, 0);
    chk("async_rst_resp_rdata", bus.resp_rdata, 0);
    chk("async_rst_mem_req",    bus.mem_req,    0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    step(4'b0000, 4'b0000, 1'b0, 1'b1, 32'h77, rdy);
    chk("post_rst_err", bus.err, 1'b1);
    chk("post_rst_resp", bus.resp_valid, 0);
    step(4'b0000, 4'b0000, 1'b0, 1'b0, '0, rdy);
    chk("err_sticky", bus.err, 1'b1);

    // random traffic against the reference model
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic rv;
      rnd_fields();
      rv = (tagq.size() > 0) ? logic'($urandom_range(0, 1)) : ($urandom_range(0, 99) == 0);
      step(NCH'($urandom), NCH'($urandom), $urandom_range(0, 3) != 0, rv, DW'($urandom), rdy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
